// File: rtl/spi_ram_slave.sv
// SPI-framed RAM slave: each frame is cmd[1:0] + payload, MSB first, captured on clk while SS_n is low.
// Define SPI_RAM_AUTOINC_EN to post-increment wr_addr on cmd 01 and rd_addr on cmd 11.
module spi_ram_slave #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int FRAME_LEN = DATA_WIDTH + 2;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RECV = 3'd1;
  localparam logic [2:0] EXEC = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] WAIT = 3'd4;

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [FRAME_LEN-1:0]  r_rx;
  logic [DATA_WIDTH-1:0] r_tx;
  logic [ADDR_SIZE-1:0]  r_wr_addr;
  logic [ADDR_SIZE-1:0]  r_rd_addr;
  logic                  r_miso;
  logic                  r_frame_err;
  logic [DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];

  logic [1:0]            w_cmd;
  logic [DATA_WIDTH-1:0] w_payload;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_wr_en;

  function automatic logic addr_in_range(input logic [ADDR_SIZE-1:0] a);
    return ({{(32-ADDR_SIZE){1'b0}}, a} < 32'(MEM_DEPTH));
  endfunction

`ifdef SPI_RAM_AUTOINC_EN
  // Wraps at the last implemented word, not at the address-space end.
  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    logic [ADDR_SIZE-1:0] nxt;
    if ({{(32-ADDR_SIZE){1'b0}}, a} == 32'(MEM_DEPTH - 1)) begin
      nxt = '0;
    end else begin
      nxt = a + ADDR_SIZE'(1);
    end
    return nxt;
  endfunction
`endif

  assign w_cmd     = r_rx[FRAME_LEN-1 -: 2];
  assign w_payload = r_rx[DATA_WIDTH-1:0];
  assign w_rd_data = addr_in_range(r_rd_addr) ? r_mem[r_rd_addr] : '0;
  assign w_wr_en   = !rst && (r_state == EXEC) && (w_cmd == CMD_WRITE) && addr_in_range(r_wr_addr);

  assign MISO      = r_miso;
  assign frame_err = r_frame_err;

  // RAM storage, deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_addr] <= w_payload;
    end
  end

  // Frame capture, command execution and serial readback state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_miso      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_miso      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!SS_n) begin
            r_rx    <= {{(FRAME_LEN-1){1'b0}}, MOSI};
            r_cnt   <= CNT_W'(1);
            r_state <= RECV;
          end
        end
        RECV: begin
          if (SS_n) begin
            r_rx        <= '0;
            r_cnt       <= '0;
            r_state     <= IDLE;
            r_frame_err <= (r_cnt != '0);
          end else begin
            r_rx  <= {r_rx[FRAME_LEN-2:0], MOSI};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(FRAME_LEN - 1)) begin
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          r_cnt   <= '0;
          r_rx    <= '0;
          r_state <= SS_n ? IDLE : WAIT;
          case (w_cmd)
            CMD_WADDR: r_wr_addr <= w_payload[ADDR_SIZE-1:0];
            CMD_WRITE: begin
`ifdef SPI_RAM_AUTOINC_EN
              r_wr_addr <= next_addr(r_wr_addr);
`endif
            end
            CMD_RADDR: r_rd_addr <= w_payload[ADDR_SIZE-1:0];
            CMD_READ: begin
              // MSB goes straight to MISO so it is visible in the first SEND cycle
              if (!SS_n) begin
                r_miso  <= w_rd_data[DATA_WIDTH-1];
                r_tx    <= {w_rd_data[DATA_WIDTH-2:0], 1'b0};
                r_state <= SEND;
              end
`ifdef SPI_RAM_AUTOINC_EN
              r_rd_addr <= next_addr(r_rd_addr);
`endif
            end
            default: r_state <= IDLE;
          endcase
        end
        SEND: begin
          if (SS_n || (r_cnt == CNT_W'(DATA_WIDTH - 1))) begin
            r_tx    <= '0;
            r_cnt   <= '0;
            r_state <= SS_n ? IDLE : WAIT;
          end else begin
            r_miso <= r_tx[DATA_WIDTH-1];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (SS_n) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_rx    <= '0;
          r_tx    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_slave.sv
// Scoreboard bench for spi_ram_slave: a default 8-bit instance and a 16-bit/10-bit-address instance
// with a non power-of-two depth; expected read words are queued by stimulus and checked by a monitor.
module tb_spi_ram_slave;

  typedef struct packed {
    logic        inst;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic ss0, mosi0, miso0, ferr0;
  logic ss1, mosi1, miso1, ferr1;

  exp_t exp_q[$];
  int   rd_req, rd_ack;
  int   n_checks, n_fail;
  int   err_exp, err_cnt0, run0;
  logic mon_en, end_req, end_done;
  logic mon_active, mon_inst;
  int   mon_bits;
  logic [15:0] mon_sh, mon_exp;

  spi_ram_slave u_dut8 (
    .clk(clk), .rst(rst), .SS_n(ss0), .MOSI(mosi0), .MISO(miso0), .frame_err(ferr0)
  );

  spi_ram_slave #(.DATA_WIDTH(16), .ADDR_SIZE(10), .MEM_DEPTH(1000)) u_dut16 (
    .clk(clk), .rst(rst), .SS_n(ss1), .MOSI(mosi1), .MISO(miso1), .frame_err(ferr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required end of stimulus");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, req);
    end
  endtask

  // Monitor: compares serialised read words against the queue and polices MISO/frame_err
  initial begin
    exp_t e;
    n_checks = 0; n_fail = 0; rd_ack = 0; err_cnt0 = 0; run0 = 0;
    mon_active = 1'b0; mon_inst = 1'b0; mon_bits = 0; mon_sh = 16'h0000; mon_exp = 16'h0000;
    end_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!(mon_active && !mon_inst)) check("miso8_quiet", 16'(miso0), 16'h0000);
        if (!(mon_active && mon_inst))  check("miso16_quiet", 16'(miso1), 16'h0000);
        run0 = ferr0 ? run0 + 1 : 0;
        if (ferr0) begin
          check("ferr8_pulse_len", 16'(run0), 16'h0001);
          if (run0 == 1) err_cnt0++;
        end
        check("ferr16_quiet", 16'(ferr1), 16'h0000);
        if (mon_active) begin
          mon_sh   = {mon_sh[14:0], (mon_inst ? miso1 : miso0)};
          mon_bits = mon_bits + 1;
          if (mon_bits == (mon_inst ? 16 : 8)) begin
            if (mon_inst) check("read16", mon_sh, mon_exp);
            else          check("read8", mon_sh, mon_exp);
            mon_active = 1'b0;
          end
        end else if (rd_ack != rd_req) begin
          rd_ack = rd_ack + 1;
          if (exp_q.size() > 0) begin
            e          = exp_q.pop_front();
            mon_inst   = e.inst;
            mon_exp    = e.data;
            mon_sh     = 16'h0000;
            mon_bits   = 0;
            mon_active = 1'b1;
          end
        end
        if (end_req && !end_done) begin
          check("ferr8_pulse_count", 16'(err_cnt0), 16'(err_exp));
          check("reads_pending", 16'(exp_q.size()), 16'h0000);
          end_done = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit inst, input logic s, input logic m);
    if (inst) begin
      ss1 = s; mosi1 = m;
    end else begin
      ss0 = s; mosi0 = m;
    end
  endtask

  task automatic frame(input bit inst, input logic [1:0] cmd, input logic [15:0] pl);
    int nb;
    nb = inst ? 16 : 8;
    drive(inst, 1'b0, cmd[1]); tick();
    drive(inst, 1'b0, cmd[0]); tick();
    for (int i = nb - 1; i >= 0; i--) begin
      drive(inst, 1'b0, pl[i]); tick();
    end
  endtask

  // via_wait=0 raises SS_n during EXEC; the command must still complete
  task automatic cmd_wr(input bit inst, input logic [1:0] cmd, input logic [15:0] pl, input bit via_wait);
    frame(inst, cmd, pl);
    if (via_wait) tick();
    drive(inst, 1'b1, 1'b0);
    tick(); tick();
  endtask

  // keep = SEND cycles before SS_n rises (or rst pulses); nb keeps the whole word
  task automatic rd(input bit inst, input logic [15:0] expv, input int keep, input bit use_rst);
    exp_t e;
    int   nb;
    nb = inst ? 16 : 8;
    frame(inst, 2'b11, 16'h0000);
    e.inst = inst; e.data = expv;
    exp_q.push_back(e);
    rd_req = rd_req + 1;
    tick();
    repeat (keep - 1) tick();
    if (use_rst) rst = 1'b1;
    else if (keep < nb) drive(inst, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(inst, 1'b1, 1'b0);
    repeat (nb + 2) tick();
  endtask

  task automatic abort8(input logic [3:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, bits[3-i]); tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    err_exp = err_exp + 1;
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; ss0 = 1'b1; mosi0 = 1'b0; ss1 = 1'b1; mosi1 = 1'b0;
    rd_req = 0; err_exp = 0; mon_en = 1'b0; end_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    // wr_addr starts at 0 after reset
    cmd_wr(1'b0, 2'b01, 16'h003C, 1'b1);
    cmd_wr(1'b0, 2'b10, 16'h0000, 1'b1);
    rd(1'b0, 16'h003C, 8, 1'b0);

    cmd_wr(1'b0, 2'b00, 16'h0005, 1'b1);
    cmd_wr(1'b0, 2'b01, 16'h00A5, 1'b1);
    cmd_wr(1'b0, 2'b10, 16'h0005, 1'b0);
    rd(1'b0, 16'h00A5, 8, 1'b0);

    cmd_wr(1'b0, 2'b00, 16'h0006, 1'b0);
    cmd_wr(1'b0, 2'b01, 16'h005A, 1'b0);
    cmd_wr(1'b0, 2'b10, 16'h0006, 1'b1);
    rd(1'b0, 16'h005A, 8, 1'b0);
    cmd_wr(1'b0, 2'b10, 16'h0005, 1'b1);
    rd(1'b0, 16'h00A5, 8, 1'b0);

    // aborted cmd 01 frames must not touch mem[5]
    cmd_wr(1'b0, 2'b00, 16'h0005, 1'b1);
    abort8(4'b0111, 4);
    abort8(4'b0000, 1);
    cmd_wr(1'b0, 2'b10, 16'h0005, 1'b1);
    rd(1'b0, 16'h00A5, 8, 1'b0);

    // SS_n raised in 3rd SEND cycle: 101 then zeros
    cmd_wr(1'b0, 2'b10, 16'h0005, 1'b1);
    rd(1'b0, 16'h00A0, 3, 1'b0);

    // rst in 5th SEND cycle: 10100 then zeros, rd_addr back to 0, RAM kept
    cmd_wr(1'b0, 2'b10, 16'h0005, 1'b1);
    rd(1'b0, 16'h00A0, 5, 1'b1);
    rd(1'b0, 16'h003C, 8, 1'b0);
    cmd_wr(1'b0, 2'b10, 16'h0005, 1'b1);
    rd(1'b0, 16'h00A5, 8, 1'b0);

    cmd_wr(1'b0, 2'b00, 16'h00FF, 1'b1);
    cmd_wr(1'b0, 2'b01, 16'h0011, 1'b1);
    cmd_wr(1'b0, 2'b01, 16'h0022, 1'b1);
    cmd_wr(1'b0, 2'b10, 16'h00FF, 1'b1);
`ifdef SPI_RAM_AUTOINC_EN
    rd(1'b0, 16'h0011, 8, 1'b0);
    cmd_wr(1'b0, 2'b10, 16'h0000, 1'b1);
    rd(1'b0, 16'h0022, 8, 1'b0);
`else
    rd(1'b0, 16'h0022, 8, 1'b0);
    cmd_wr(1'b0, 2'b10, 16'h0000, 1'b1);
    rd(1'b0, 16'h003C, 8, 1'b0);
`endif

    // wide instance: last word 999 holds data, 0x3FF and 1000 are out of range
    cmd_wr(1'b1, 2'b00, 16'h03E7, 1'b1);
    cmd_wr(1'b1, 2'b01, 16'hBEEF, 1'b1);
    cmd_wr(1'b1, 2'b10, 16'h03E7, 1'b1);
    rd(1'b1, 16'hBEEF, 16, 1'b0);
    cmd_wr(1'b1, 2'b00, 16'h03FF, 1'b1);
    cmd_wr(1'b1, 2'b01, 16'h1234, 1'b1);
    cmd_wr(1'b1, 2'b10, 16'h03FF, 1'b1);
    rd(1'b1, 16'h0000, 16, 1'b0);
    cmd_wr(1'b1, 2'b10, 16'h03E8, 1'b1);
    rd(1'b1, 16'h0000, 16, 1'b0);
    cmd_wr(1'b1, 2'b00, 16'h0000, 1'b0);
    cmd_wr(1'b1, 2'b01, 16'h8001, 1'b1);
    cmd_wr(1'b1, 2'b10, 16'h0000, 1'b1);
    rd(1'b1, 16'h8001, 16, 1'b0);
    cmd_wr(1'b1, 2'b10, 16'h03E7, 1'b1);
    rd(1'b1, 16'hBEEF, 16, 1'b0);

    end_req = 1'b1;
    for (int i = 0; i < 20 && !end_done; i++) tick();
    if (!end_done) begin
      $display("FAIL end_handshake: monitor done=0, required 1");
      $fatal(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave.md
SPI_RAM_SLAVE -- requirements
Module: spi_ram_slave

Interface
REQ-001: Parameter DATA_WIDTH, default 8, RAM word width and frame payload width in bits.
REQ-002: Parameter ADDR_SIZE, default 8, address width; legal range 1 to DATA_WIDTH.
REQ-003: Parameter MEM_DEPTH, default 256, number of RAM words; legal range 2 to 2**ADDR_SIZE.
REQ-004: clk  input  1  single clock; all state changes on its rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: SS_n  input  1  slave select, active low.
REQ-007: MOSI  input  1  serial data from master, MSB first.
REQ-008: MISO  output  1  serial read data to master, MSB first.
REQ-009: frame_err  output  1  one-cycle pulse on an aborted incoming frame.

Function
REQ-010: Frame format SHALL be 2+DATA_WIDTH bits: cmd[1:0], then payload[DATA_WIDTH-1:0], MSB first.
REQ-011: FSM states SHALL be IDLE, RECV, EXEC, SEND and WAIT.
REQ-012: MOSI SHALL be sampled on each rising edge where SS_n=0 and the state is IDLE or RECV; IDLE->RECV on the first sampled bit.
REQ-013: RECV->EXEC SHALL occur on the edge capturing bit 2+DATA_WIDTH; EXEC SHALL last exactly one cycle.
REQ-014: cmd 00 in EXEC SHALL load payload[ADDR_SIZE-1:0] into wr_addr; next state WAIT.
REQ-015: cmd 01 in EXEC SHALL write payload to mem[wr_addr]; next state WAIT.
REQ-016: cmd 10 in EXEC SHALL load payload[ADDR_SIZE-1:0] into rd_addr; next state WAIT.
REQ-017: cmd 11 in EXEC SHALL load mem[rd_addr] into the transmit shift register; payload ignored; next state SEND.
REQ-018: In SEND, MISO SHALL present tx bit DATA_WIDTH-1 on the first SEND cycle and shift one bit per clock; after DATA_WIDTH cycles SEND->WAIT.
REQ-019: MISO SHALL be 0 in every state other than SEND.
REQ-020: WAIT SHALL ignore MOSI and SHALL move to IDLE on the first edge with SS_n=1.
REQ-021: SS_n=1 in RECV SHALL return to IDLE next edge, discard captured bits, leave RAM and pointers unchanged, and pulse frame_err if at least one bit was captured.
REQ-022: SS_n=1 in EXEC SHALL still complete the command and then go to IDLE.
REQ-023: SS_n=1 in SEND SHALL return to IDLE next edge with MISO=0; frame_err SHALL stay 0.
REQ-024: Write to address >= MEM_DEPTH SHALL be dropped; read from address >= MEM_DEPTH SHALL return all zeros.
REQ-025: Back-to-back frames SHALL require SS_n high for at least one clock between them.

Reset
REQ-026: rst=1 SHALL force state IDLE, MISO=0, frame_err=0, wr_addr=0, rd_addr=0, bit counter=0, shift registers=0, on the next edge, in any state including mid-frame.
REQ-027: RAM contents SHALL NOT be cleared by reset.
REQ-028: rst SHALL take priority over all other inputs.

Configuration
REQ-029: Macro SPI_RAM_AUTOINC_EN SHALL control pointer auto-increment.
REQ-030: Defined: cmd 01 SHALL increment wr_addr and cmd 11 SHALL increment rd_addr in the EXEC cycle, wrapping MEM_DEPTH-1 -> 0, including for dropped or out-of-range accesses.
REQ-031: Undefined: wr_addr and rd_addr SHALL change only via cmd 00/10 or reset.

Verification
REQ-032: Defaults; frames 00+0x05, 01+0xA5, 10+0x05, 11+0x00 -> MISO serialises 10100101 over 8 SEND cycles.
REQ-033: SS_n raised after 4 bits of a cmd 01 frame -> frame_err high exactly 1 cycle; mem[wr_addr] unchanged.
REQ-034: AUTOINC_EN, wr_addr=0xFF, two cmd 01 frames 0x11 then 0x22 -> mem[255]=0x11, mem[0]=0x22.
REQ-035: MEM_DEPTH=200, cmd 10+0xC8 then cmd 11 -> MISO all zeros; prior write to 0xC8 had no effect.
REQ-036: rst pulsed in 5th SEND cycle -> next edge IDLE, MISO=0, rd_addr=0; RAM data retained on re-read.
REQ-037: DATA_WIDTH=16, ADDR_SIZE=10, MEM_DEPTH=1024: 18-bit frames write/read 0xBEEF at 0x3FF -> 16-bit MISO readback 0xBEEF.
